rx_frame_logger: RTL and testbench

RX_FRAME_LOGGER -- requirements
Module: rx_frame_logger

---
 rtl/rx_frame_logger.sv | 110 +++++++++++
 tb/tb_rx_frame_logger.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_logger.sv
// rx_frame_logger: per-port rising-edge frame capture, round-robin arbitration into a display log FIFO.
// Define RX_LOG_SFD_CHECK_EN to drop frames whose SFD nibble is not 4'b0101 and count them in err_count.
module rx_frame_logger #(
  parameter int DEPTH = 4,
  parameter int PORTS = 4
) (
  input  logic        FPGA_CLK,
  input  logic        sys_rst,
  input  logic [15:0] rx_frame_0,
  input  logic [15:0] rx_frame_1,
  input  logic [15:0] rx_frame_2,
  input  logic [15:0] rx_frame_3,
  input  logic [3:0]  rx_valid,
  input  logic        clear,
  input  logic        disp_next,
  output logic        disp_valid,
  output logic [7:0]  disp_addr,
  output logic [7:0]  disp_payload,
  output logic [4:0]  log_count,
  output logic        overflow,
  output logic [3:0]  err_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RX_LOG_SFD_CHECK_EN
  localparam bit SFD_EN = 1'b1;
`else
  localparam bit SFD_EN = 1'b0;
`endif
  logic [PORTS-1:0] prev, pending, rise, gnt_oh;
  logic [15:0]      frame [PORTS];
  logic [15:0]      cap [PORTS];
  logic [1:0]       rr, gnt_port, wr_port;
  logic             gnt, wr_vld, dn_prev, pop, push, sfd_ok;
  logic [15:0]      wr_frame;
  logic [13:0]      mem [DEPTH];
  logic [13:0]      head;
  logic [AW-1:0]    wp, rp;
  always_comb begin
    frame[0] = rx_frame_0;
    frame[1] = rx_frame_1;
    frame[2] = rx_frame_2;
    frame[3] = rx_frame_3;
  end
  // Highest offset first so the port nearest rr wins.
  always_comb begin
    gnt      = 1'b0;
    gnt_port = rr;
    for (int i = PORTS - 1; i >= 0; i--)
      if (pending[rr + 2'(i)]) begin
        gnt      = 1'b1;
        gnt_port = rr + 2'(i);
      end
  end
  always_comb begin
    rise   = rx_valid & ~prev;
    gnt_oh = gnt ? (PORTS'(1) << gnt_port) : '0;
    pop    = disp_next & ~dn_prev & (log_count != 5'd0);
    sfd_ok = !SFD_EN || (wr_frame[15:12] == 4'b0101);
    push   = wr_vld & sfd_ok & ((log_count != 5'(DEPTH)) | pop);
    head   = mem[rp];
  end
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      prev      <= '0;
      pending   <= '0;
      rr        <= '0;
      dn_prev   <= 1'b0;
      wr_vld    <= 1'b0;
      wr_port   <= '0;
      wr_frame  <= '0;
      wp        <= '0;
      rp        <= '0;
      log_count <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < PORTS; i++) cap[i] <= '0;
    end else begin
      prev    <= rx_valid;
      dn_prev <= disp_next;
      if (clear) begin
        pending   <= '0;
        wr_vld    <= 1'b0;
        wp        <= '0;
        rp        <= '0;
        log_count <= '0;
        overflow  <= 1'b0;
        err_count <= '0;
      end else begin
        pending  <= (pending & ~gnt_oh) | rise;
        for (int i = 0; i < PORTS; i++) if (rise[i]) cap[i] <= frame[i];
        if (gnt) rr <= gnt_port + 2'd1;
        wr_vld   <= gnt;
        wr_port  <= gnt_port;
        wr_frame <= cap[gnt_port];
        if (push) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        log_count <= log_count + 5'(push) - 5'(pop);
        if (wr_vld && sfd_ok && !push) overflow <= 1'b1;
        if (SFD_EN && wr_vld && !sfd_ok && err_count != 4'hF) err_count <= err_count + 4'd1;
      end
    end
  end
  always_ff @(posedge FPGA_CLK)
    if (push && !clear) mem[wp] <= {wr_port, wr_frame[11:0]};
  always_comb begin
    disp_valid   = log_count != 5'd0;
    disp_addr    = disp_valid ? head[11:4] : 8'h00;
    disp_payload = disp_valid ? {2'b00, head[13:12], head[3:0]} : 8'h00;
  end
endmodule

// File: tb/tb_rx_frame_logger.sv
// tb_rx_frame_logger: directed vector table, hand sequences and a queue-based random reference model.
module tb_rx_frame_logger;
  localparam int DEPTH = 4;
`ifdef RX_LOG_SFD_CHECK_EN
  localparam bit SFD = 1'b1;
`else
  localparam bit SFD = 1'b0;
`endif
  logic        FPGA_CLK = 1'b0;
  logic        sys_rst;
  logic [15:0] rx_frame_0, rx_frame_1, rx_frame_2, rx_frame_3;
  logic [3:0]  rx_valid;
  logic        clear, disp_next;
  logic        disp_valid, overflow;
  logic [7:0]  disp_addr, disp_payload;
  logic [4:0]  log_count;
  logic [3:0]  err_count;
  int checks = 0;
  int errors = 0;
  rx_frame_logger #(.DEPTH(DEPTH), .PORTS(4)) dut (
    .FPGA_CLK(FPGA_CLK), .sys_rst(sys_rst),
    .rx_frame_0(rx_frame_0), .rx_frame_1(rx_frame_1), .rx_frame_2(rx_frame_2), .rx_frame_3(rx_frame_3),
    .rx_valid(rx_valid), .clear(clear), .disp_next(disp_next),
    .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_payload(disp_payload),
    .log_count(log_count), .overflow(overflow), .err_count(err_count)
  );
  always #5 FPGA_CLK = ~FPGA_CLK;
  typedef struct {
    logic [3:0] rv;
    logic       dn, clr, rst, dv;
    logic [7:0] addr, pay;
    logic [4:0] cnt;
    logic       ovf;
  } vec_t;
  vec_t tv [19];
  // Reference model state
  bit [3:0]    m_prev, m_pend;
  logic [15:0] m_cap [4];
  int          m_rr, m_err;
  bit          m_infl, m_dnprev, m_ovf;
  bit [1:0]    m_iport;
  logic [15:0] m_iframe;
  bit [13:0]   m_q [$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [22:0] outs();
    return {disp_valid, disp_addr, disp_payload, log_count, overflow};
  endfunction
  task automatic tick();
    @(posedge FPGA_CLK);
    #1;
  endtask
  task automatic pulse_rst();
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
  endtask
  function automatic logic [15:0] cur_frame(input int n);
    return n == 0 ? rx_frame_0 : n == 1 ? rx_frame_1 : n == 2 ? rx_frame_2 : rx_frame_3;
  endfunction
  task automatic m_reset();
    m_prev = 0; m_pend = 0; m_rr = 0; m_err = 0; m_infl = 0;
    m_dnprev = 0; m_ovf = 0; m_q.delete();
    for (int n = 0; n < 4; n++) m_cap[n] = '0;
  endtask
  task automatic m_step();
    bit pop;
    int g;
    if (clear) begin
      m_q.delete(); m_pend = 0; m_infl = 0; m_ovf = 0; m_err = 0;
    end else begin
      pop = disp_next && !m_dnprev && m_q.size() > 0;
      if (pop) m_q.delete(0);
      if (m_infl) begin
        if (SFD && m_iframe[15:12] != 4'h5) m_err = (m_err < 15) ? m_err + 1 : 15;
        else if (m_q.size() < DEPTH) m_q.push_back({m_iport, m_iframe[11:0]});
        else m_ovf = 1;
      end
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      m_infl = g >= 0;
      if (g >= 0) begin
        m_iport = 2'(g); m_iframe = m_cap[g]; m_pend[g] = 0; m_rr = (g + 1) % 4;
      end
      for (int n = 0; n < 4; n++)
        if (rx_valid[n] && !m_prev[n]) begin
          m_pend[n] = 1; m_cap[n] = cur_frame(n);
        end
    end
    m_prev = rx_valid; m_dnprev = disp_next;
  endtask
  function automatic logic [26:0] m_exp();
    bit [13:0] hd;
    bit ne;
    ne = m_q.size() > 0;
    hd = ne ? m_q[0] : 14'h0;
    return {ne, ne ? hd[11:4] : 8'h00, ne ? {2'b00, hd[13:12], hd[3:0]} : 8'h00,
            5'(m_q.size()), m_ovf, 4'(m_err)};
  endfunction
  initial begin
    tv[0]  = '{4'b0100, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0};
    tv[1]  = '{4'b0100, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0};
    tv[2]  = '{4'b0100, 0, 0, 0, 1, 8'hCA, 8'h27, 5'd1, 0};
    tv[3]  = '{4'b0000, 1, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0};
    tv[4]  = '{4'b1111, 0, 0, 1, 0, 8'h00, 8'h00, 5'd0, 0};
    tv[5]  = '{4'b1111, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0};
    tv[6]  = '{4'b1111, 0, 0, 0, 1, 8'h12, 8'h00, 5'd1, 0};
    tv[7]  = '{4'b1111, 0, 0, 0, 1, 8'h12, 8'h00, 5'd2, 0};
    tv[8]  = '{4'b1111, 0, 0, 0, 1, 8'h12, 8'h00, 5'd3, 0};
    tv[9]  = '{4'b1111, 0, 0, 0, 1, 8'h12, 8'h00, 5'd4, 0};
    tv[10] = '{4'b1111, 1, 0, 0, 1, 8'h34, 8'h11, 5'd3, 0};
    tv[11] = '{4'b1111, 0, 0, 0, 1, 8'h34, 8'h11, 5'd3, 0};
    tv[12] = '{4'b1111, 1, 0, 0, 1, 8'hCA, 8'h27, 5'd2, 0};
    tv[13] = '{4'b0000, 0, 0, 0, 1, 8'hCA, 8'h27, 5'd2, 0};
    tv[14] = '{4'b0001, 0, 0, 0, 1, 8'hCA, 8'h27, 5'd2, 0};
    tv[15] = '{4'b0001, 0, 0, 0, 1, 8'hCA, 8'h27, 5'd2, 0};
    tv[16] = '{4'b0001, 1, 0, 0, 1, 8'h56, 8'h33, 5'd2, 0};
    tv[17] = '{4'b0001, 0, 0, 0, 1, 8'h56, 8'h33, 5'd2, 0};
    tv[18] = '{4'b0001, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0, 0};
    sys_rst = 1'b1; rx_valid = '0; clear = 0; disp_next = 0;
    rx_frame_0 = 16'h5120; rx_frame_1 = 16'h5341; rx_frame_2 = 16'h5CA7; rx_frame_3 = 16'h5563;
    repeat (2) @(posedge FPGA_CLK);
    #1;
    chk("reset_state", {outs(), err_count}, 27'h0);
    sys_rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (tv[i].rst) pulse_rst();
      rx_valid = tv[i].rv; disp_next = tv[i].dn; clear = tv[i].clr;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {tv[i].dv, tv[i].addr, tv[i].pay, tv[i].cnt, tv[i].ovf});
    end
    clear = 0; disp_next = 0; rx_valid = '0;
    tick();
    // Six frames into a four-deep log with no pops
    for (int k = 0; k < 6; k++) begin
      rx_frame_1 = {4'h5, 4'h9, 4'(k), 4'hE};
      rx_valid = 4'b0010; tick();
      rx_valid = 4'b0000; tick();
    end
    repeat (3) tick();
    chk("overflow_full", outs(), {1'b1, 8'h90, 8'h1E, 5'd4, 1'b1});
    clear = 1; tick(); clear = 0;
    chk("clear_flush", outs(), 23'h0);
    rx_frame_1 = 16'h3AB1;
    rx_valid = 4'b0010; tick(); rx_valid = 4'b0000; repeat (3) tick();
    chk("sfd_first", {log_count, err_count}, SFD ? {5'd0, 4'd1} : {5'd1, 4'd0});
    for (int k = 0; k < 15; k++) begin
      rx_valid = 4'b0010; tick(); rx_valid = 4'b0000; tick();
    end
    repeat (3) tick();
    chk("sfd_many", {log_count, err_count}, SFD ? {5'd0, 4'd15} : {5'd4, 4'd0});
    clear = 1; tick(); clear = 0;
    // Reset one cycle after a capture edge must lose the frame
    rx_frame_0 = 16'h5777;
    rx_valid = 4'b0001; tick();
    sys_rst = 1'b1; rx_valid = 4'b0000;
    tick();
    sys_rst = 1'b0;
    repeat (4) tick();
    chk("reset_midcap", {outs(), err_count}, 27'h0);
    pulse_rst();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) rx_valid[$urandom_range(3)] = ~rx_valid[$urandom_range(3)];
      rx_frame_0 = {($urandom_range(3) != 0) ? 4'h5 : 4'($urandom), 12'($urandom)};
      rx_frame_1 = {($urandom_range(3) != 0) ? 4'h5 : 4'($urandom), 12'($urandom)};
      rx_frame_2 = {($urandom_range(3) != 0) ? 4'h5 : 4'($urandom), 12'($urandom)};
      rx_frame_3 = {($urandom_range(3) != 0) ? 4'h5 : 4'($urandom), 12'($urandom)};
      if ($urandom_range(2) == 0) disp_next = ~disp_next;
      clear = $urandom_range(63) == 0;
      if ($urandom_range(499) == 0) begin
        sys_rst = 1'b1;
        #1;
        chk("rand_rst", {outs(), err_count}, 27'h0);
        m_reset();
        sys_rst = 1'b0;
      end
      tick();
      m_step();
      chk($sformatf("rand%0d", c), {outs(), err_count}, m_exp());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
